// File: rtl/shift_arbiter_pkg.sv
// ============================================================================
//  shift_arbiter_pkg : shared defaults, shift direction codes, request record
//  Revision: 1.0
// ============================================================================
`default_nettype none

package shift_arbiter_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_SHW   = 3;

    localparam logic SHIFT_LEFT  = 1'b1;
    localparam logic SHIFT_RIGHT = 1'b0;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic [DEF_SHW-1:0]   n;
        logic                 lr;
    } shift_req_t;

endpackage

`default_nettype wire

// File: rtl/shift_arbiter_shift_core.sv
// ============================================================================
//  shift_core : combinational logical (zero-fill) left/right shifter
//  Revision: 1.0
// ============================================================================
`default_nettype none

module shift_core
    import shift_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_n,
    input  logic             i_lr,
    output logic [WIDTH-1:0] o_data
);

    always_comb begin
        if (i_lr == SHIFT_LEFT) begin
            o_data = i_data << i_n;
        end else begin
            o_data = i_data >> i_n;
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_arbiter.sv
// ============================================================================
//  shift_arbiter : round-robin sharing of one shifter between NREQ requesters,
//                  single registered result slot with valid/ready handshake
//  Revision: 1.0
// ============================================================================
`default_nettype none

module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = DEF_SHW,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    input  logic [NREQ*SHW-1:0]      req_n,
    input  logic [NREQ-1:0]          req_lr,
    output logic [NREQ-1:0]          gnt,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic [CNTW-1:0]          ops_count
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]   ptr_q,       ptr_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic [IDW-1:0]   res_id_q,    res_id_d;
    logic [CNTW-1:0]  ops_count_q, ops_count_d;

    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_sel;
    logic             w_found;
    logic             w_slot_free;
    logic             w_grant;
    logic             w_drain;
    logic [WIDTH-1:0] w_sel_data;
    logic [SHW-1:0]   w_sel_n;
    logic             w_sel_lr;
    logic [WIDTH-1:0] w_shifted;

    // Rotating search starting just after the last winner.
    always_comb begin
        int cand;
        cand        = 0;
        w_gnt       = '0;
        w_sel       = '0;
        w_found     = 1'b0;
        w_slot_free = !res_valid_q || res_ready;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (!w_found && req[cand]) begin
                w_found = 1'b1;
                w_sel   = IDW'(cand);
            end
        end
        if (w_found && w_slot_free && !rst) begin
            w_gnt[w_sel] = 1'b1;
        end
    end

    assign w_grant    = |w_gnt;
    assign w_drain    = res_valid_q && res_ready;
    assign w_sel_data = req_data[int'(w_sel)*WIDTH +: WIDTH];
    assign w_sel_n    = req_n[int'(w_sel)*SHW +: SHW];
    assign w_sel_lr   = req_lr[w_sel];

    shift_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shift_core (
        .i_data (w_sel_data),
        .i_n    (w_sel_n),
        .i_lr   (w_sel_lr),
        .o_data (w_shifted)
    );

    // A grant on the same edge as a drain overwrites the slot, keeping valid high.
    always_comb begin
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        ops_count_d = ops_count_q;
        if (w_grant) begin
            res_valid_d = 1'b1;
            res_data_d  = w_shifted;
            res_id_d    = w_sel;
            ptr_d       = w_sel;
        end else if (w_drain) begin
            res_valid_d = 1'b0;
        end
        if (w_drain) begin
            ops_count_d = ops_count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= IDW'(NREQ - 1);
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            ops_count_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            ops_count_q <= ops_count_d;
        end
    end

    assign gnt       = w_gnt;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign ops_count = ops_count_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ============================================================================
//  tb_shift_arbiter : self-checking bench for shift_arbiter
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shift_arbiter;
    import shift_arbiter_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int SHW   = 3;
    localparam int CNTW  = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*SHW-1:0]   req_n;
    logic [NREQ-1:0]       req_lr;
    logic [NREQ-1:0]       gnt;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_data;
    logic [1:0]            res_id;
    logic [CNTW-1:0]       ops_count;

    shift_req_t ops [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_data[g*WIDTH +: WIDTH] = ops[g].data;
        assign req_n[g*SHW +: SHW]        = ops[g].n;
        assign req_lr[g]                  = ops[g].lr;
    end

    shift_arbiter #(
        .NREQ (NREQ), .WIDTH (WIDTH), .SHW (SHW), .CNTW (CNTW)
    ) dut (
        .clk (clk), .rst (rst), .req (req), .req_data (req_data),
        .req_n (req_n), .req_lr (req_lr), .gnt (gnt),
        .res_valid (res_valid), .res_ready (res_ready),
        .res_data (res_data), .res_id (res_id), .ops_count (ops_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: one result slot, last winner, delivered count.
    bit m_valid;
    int m_data;
    int m_id;
    int m_ptr;
    int m_cnt;

    function automatic int ref_shift(int d, int n, bit left);
        if (left) return (d * (1 << n)) % 256;
        return d / (1 << n);
    endfunction

    function automatic int model_pick();
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] model_gnt();
        int p;
        if (rst) return '0;
        if (m_valid && !res_ready) return '0;
        p = model_pick();
        if (p < 0) return '0;
        return NREQ'(1 << p);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_data = 0; m_id = 0; m_ptr = NREQ - 1; m_cnt = 0;
    endtask

    task automatic step();
        int p;
        bit hs;
        @(posedge clk);
        p  = model_pick();
        hs = m_valid && res_ready;
        if (!rst) begin
            if (p >= 0 && (!m_valid || res_ready)) begin
                m_data  = ref_shift(int'(ops[p].data), int'(ops[p].n), ops[p].lr);
                m_id    = p;
                m_valid = 1'b1;
                m_ptr   = p;
            end else if (hs) begin
                m_valid = 1'b0;
            end
            if (hs) m_cnt = (m_cnt + 1) % 65536;
        end
        #1;
    endtask

    task automatic random_ops();
        for (int i = 0; i < NREQ; i++) begin
            ops[i].data = 8'($urandom);
            ops[i].n    = 3'($urandom);
            ops[i].lr   = 1'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '1; res_ready = 1'b1; random_ops();
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", res_valid); end
        checks++; if (res_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", res_data); end
        checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", res_id); end
        checks++; if (ops_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ops_count); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        rst = 1'b0; req = '0;
        model_reset();
    endtask

    task automatic test_basic();
        @(negedge clk);
        req = 4'b0001; res_ready = 1'b1;
        ops[0].data = 8'hB5; ops[0].n = 3'd3; ops[0].lr = SHIFT_LEFT;
        #1;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL basic_gnt got=%b exp=0001", gnt); end
        step();
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", res_valid); end
        checks++; if (res_data !== 8'hA8) begin failures++; $display("FAIL basic_data got=%h exp=a8", res_data); end
        checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL basic_id got=%0d exp=0", res_id); end
        @(negedge clk);
        req = '0;
        step();
        checks++; if (ops_count !== 16'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", ops_count); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%0b exp=0", res_valid); end
    endtask

    task automatic test_round_robin();
        int start;
        int e;
        start = (m_ptr + 1) % NREQ;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req = '1; res_ready = 1'b1; random_ops();
            e = (start + c) % NREQ;
            #1;
            checks++; if (gnt !== NREQ'(1 << e)) begin failures++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, gnt, NREQ'(1 << e)); end
            step();
            checks++; if (res_id !== 2'(e) || res_valid !== 1'b1) begin failures++; $display("FAIL rr_id cyc=%0d got=%0d/%0b exp=%0d/1", c, res_id, res_valid, e); end
            checks++; if (res_data !== 8'(m_data)) begin failures++; $display("FAIL rr_data cyc=%0d got=%h exp=%h", c, res_data, 8'(m_data)); end
        end
        checks++; if (ops_count !== 16'(m_cnt)) begin failures++; $display("FAIL rr_count got=%0d exp=%0d", ops_count, m_cnt); end
    endtask

    task automatic test_shift_cases();
        int         t_idx [4] = '{2, 0, 1, 3};
        logic [7:0] t_d   [4] = '{8'hB5, 8'h5A, 8'h5A, 8'hFF};
        logic [2:0] t_n   [4] = '{3'd2, 3'd0, 3'd0, 3'd7};
        logic       t_lr  [4] = '{SHIFT_RIGHT, SHIFT_LEFT, SHIFT_RIGHT, SHIFT_LEFT};
        logic [7:0] t_exp [4] = '{8'h2D, 8'h5A, 8'h5A, 8'h80};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req = NREQ'(1 << t_idx[c]); res_ready = 1'b1;
            ops[t_idx[c]].data = t_d[c]; ops[t_idx[c]].n = t_n[c]; ops[t_idx[c]].lr = t_lr[c];
            step();
            checks++; if (res_data !== t_exp[c]) begin failures++; $display("FAIL shift_data case=%0d got=%h exp=%h", c, res_data, t_exp[c]); end
            checks++; if (res_id !== 2'(t_idx[c])) begin failures++; $display("FAIL shift_id case=%0d got=%0d exp=%0d", c, res_id, t_idx[c]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  s_data;
        logic [1:0]  s_id;
        logic [15:0] s_cnt;
        @(negedge clk);
        req = 4'b0100; res_ready = 1'b1; random_ops();
        step();
        @(negedge clk);
        res_ready = 1'b0; req = 4'b0110;
        s_data = res_data; s_id = res_id; s_cnt = ops_count;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL bp_gnt cyc=%0d got=%b exp=0000", c, gnt); end
            step();
            checks++; if (res_data !== s_data || res_id !== s_id || res_valid !== 1'b1) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h/%0d/%0b exp=%h/%0d/1", c, res_data, res_id, res_valid, s_data, s_id); end
            checks++; if (ops_count !== s_cnt) begin failures++; $display("FAIL bp_count cyc=%0d got=%0d exp=%0d", c, ops_count, s_cnt); end
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL bp_release_gnt got=%b exp=0010", gnt); end
        step();
        checks++; if (ops_count !== s_cnt + 16'd1) begin failures++; $display("FAIL bp_release_count got=%0d exp=%0d", ops_count, s_cnt + 16'd1); end
        checks++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 8'(m_data)) begin failures++; $display("FAIL bp_release_res got=%0b/%0d/%h exp=1/1/%h", res_valid, res_id, res_data, 8'(m_data)); end
    endtask

    task automatic test_midreset();
        @(negedge clk);
        res_ready = 1'b0; req = '0;
        #2 rst = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0 || res_data !== 8'h00) begin failures++; $display("FAIL mrst_res got=%0b/%h exp=0/00", res_valid, res_data); end
        req = '1;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL mrst_gnt got=%b exp=0000", gnt); end
        model_reset();
        @(posedge clk); @(negedge clk);
        rst = 1'b0; req = 4'b1001; res_ready = 1'b1; random_ops();
        #1;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL mrst_prio got=%b exp=0001", gnt); end
        step();
        checks++; if (res_id !== 2'd0 || res_data !== 8'(m_data)) begin failures++; $display("FAIL mrst_res2 got=%0d/%h exp=0/%h", res_id, res_data, 8'(m_data)); end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] eg;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req = NREQ'($urandom); res_ready = ($urandom_range(0, 3) != 0); random_ops();
            #1;
            eg = model_gnt();
            checks++; if (gnt !== eg) begin failures++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", c, gnt, eg); end
            step();
            checks++; if (res_valid !== m_valid || res_data !== 8'(m_data) || res_id !== 2'(m_id)) begin failures++; $display("FAIL rand_res cyc=%0d got=%0b/%h/%0d exp=%0b/%h/%0d", c, res_valid, res_data, res_id, m_valid, 8'(m_data), m_id); end
            checks++; if (ops_count !== 16'(m_cnt)) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, ops_count, m_cnt); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) ops[i] = '0;
        model_reset();
        test_reset();
        test_basic();
        test_round_robin();
        test_shift_cases();
        test_backpressure();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
